// File: rtl/crp16_mul_seq.sv
// Iterative 16x16 shift-and-add multiplier that borrows the CRP16 ALU for one add per cycle.
// Define CRP16_MUL_SIGNED_EN to enable two's-complement multiplies via signed_op_i.
module crp16_mul_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        signed_op_i,
    input  logic [15:0] mcand_i,
    input  logic [15:0] mplier_i,
    output logic [15:0] alu_x_o,
    output logic [15:0] alu_y_o,
    output logic [3:0]  alu_sel_o,
    input  logic [15:0] alu_out_i,
    input  logic        alu_c_i,
    input  logic        alu_v_i,
    input  logic        alu_n_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] prod_hi_o,
    output logic [15:0] prod_lo_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [3:0] SelAddU = 4'b0000;
    localparam logic [3:0] SelAddS = 4'b0010;
    localparam logic [3:0] SelSubS = 4'b0011;

    state_e      state_q, state_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] mcand_q, mcand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic        sgn_cap;
    logic        shift_in;

`ifdef CRP16_MUL_SIGNED_EN
    assign sgn_cap = signed_op_i;
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op_i;
    assign sgn_cap          = 1'b0;
`endif

    // True sign of the 17-bit sum in signed mode, carry-out in unsigned mode.
    assign shift_in = sgn_q ? (alu_n_i ^ alu_v_i) : alu_c_i;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        alu_x_o   = 16'h0000;
        alu_y_o   = 16'h0000;
        alu_sel_o = SelAddU;
        busy_o    = 1'b0;
        done_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    hi_d    = 16'h0000;
                    lo_d    = mplier_i;
                    mcand_d = mcand_i;
                    cnt_d   = 4'd0;
                    sgn_d   = sgn_cap;
                end
            end
            StRun: begin
                busy_o  = 1'b1;
                alu_x_o = hi_q;
                alu_y_o = lo_q[0] ? mcand_q : 16'h0000;
                if (sgn_q) begin
                    // Multiplier sign bit carries weight -2^15, so the last step subtracts.
                    alu_sel_o = (cnt_q == 4'd15 && lo_q[0]) ? SelSubS : SelAddS;
                end
                hi_d = {shift_in, alu_out_i[15:1]};
                lo_d = {alu_out_i[0], lo_q[15:1]};
                if (cnt_q == 4'd15) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                done_o = 1'b1;
                if (start_i) begin
                    state_d = StRun;
                    hi_d    = 16'h0000;
                    lo_d    = mplier_i;
                    mcand_d = mcand_i;
                    cnt_d   = 4'd0;
                    sgn_d   = sgn_cap;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            hi_q    <= 16'h0000;
            lo_q    <= 16'h0000;
            mcand_q <= 16'h0000;
            cnt_q   <= 4'd0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
        end
    end

    assign prod_hi_o = hi_q;
    assign prod_lo_o = lo_q;

endmodule

// File: tb/tb_crp16_mul_seq.sv
// Bench for crp16_mul_seq: models the external ALU, scoreboards products against a reference
// multiply, and checks latency, handshake and reset behaviour.
module tb_crp16_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [3:0]  alu_sel;
    logic [15:0] alu_out;
    logic        alu_c;
    logic        alu_v;
    logic        alu_n;
    logic        busy;
    logic        done;
    logic [15:0] prod_hi;
    logic [15:0] prod_lo;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_q[$];
    logic        sel_nonzero_seen;

    crp16_mul_seq dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .signed_op_i(signed_op),
        .mcand_i    (mcand),
        .mplier_i   (mplier),
        .alu_x_o    (alu_x),
        .alu_y_o    (alu_y),
        .alu_sel_o  (alu_sel),
        .alu_out_i  (alu_out),
        .alu_c_i    (alu_c),
        .alu_v_i    (alu_v),
        .alu_n_i    (alu_n),
        .busy_o     (busy),
        .done_o     (done),
        .prod_hi_o  (prod_hi),
        .prod_lo_o  (prod_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: add for selects 0000/0010, subtract for 0011.
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum = 17'h0;
        alu_v   = 1'b0;
        if (alu_sel == 4'b0011) begin
            alu_sum = {1'b0, alu_x} + {1'b0, ~alu_y} + 17'd1;
            alu_v   = (alu_x[15] != alu_y[15]) && (alu_sum[15] != alu_x[15]);
        end else begin
            alu_sum = {1'b0, alu_x} + {1'b0, alu_y};
            alu_v   = (alu_x[15] == alu_y[15]) && (alu_sum[15] != alu_x[15]);
        end
        alu_out = alu_sum[15:0];
        alu_c   = alu_sum[16];
        alu_n   = alu_sum[15];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
        logic [31:0] sa;
        logic [31:0] sb;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
`ifdef CRP16_MUL_SIGNED_EN
        if (s) return sa * sb;
`endif
        if (s && (sa == sb)) return {16'h0, a} * {16'h0, b};
        return {16'h0, a} * {16'h0, b};
    endfunction

    // Scoreboard consumer: each done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (!rst) begin
            if (alu_sel != 4'b0000) sel_nonzero_seen = 1'b1;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    check_eq("sb_product", {prod_hi, prod_lo}, exp_q.pop_front());
                end
            end
        end
    end

    // Called at a negedge: present operands and raise start; optionally log expected product.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input bit push);
        mcand     = a;
        mplier    = b;
        signed_op = s;
        start     = 1'b1;
        if (push) exp_q.push_back(model(a, b, s));
    endtask

    // Lets the accepting edge pass, then counts negedges to done; poke_at>0 re-pulses start.
    task automatic wait_done(input int poke_at, output int lat, output int busy_cnt);
        @(posedge clk);
        #1 start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (poke_at > 0 && lat == poke_at) begin
                mcand  = 16'hDEAD;
                mplier = 16'hBEEF;
                start  = 1'b1;
            end
            if (poke_at > 0 && lat == poke_at + 1) start = 1'b0;
            if (done) break;
        end
        if (!done) check_eq("timeout_done", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [31:0] want);
        int lat;
        int bc;
        @(negedge clk);
        issue(a, b, s, 1'b1);
        wait_done(0, lat, bc);
        check_eq({tag, "_latency"}, lat, 32'd17);
        check_eq({tag, "_product"}, {prod_hi, prod_lo}, want);
    endtask

    initial begin
        int lat;
        int bc;
        logic [15:0] ra;
        logic [15:0] rb;
        n_vec            = 0;
        n_err            = 0;
        sel_nonzero_seen = 1'b0;
        rst              = 1'b1;
        start            = 1'b0;
        signed_op        = 1'b0;
        mcand            = 16'h0;
        mplier           = 16'h0;
        repeat (2) @(negedge clk);

        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_prod", {prod_hi, prod_lo}, 32'd0);
        check_eq("rst_alu_x", {16'b0, alu_x}, 32'd0);
        check_eq("rst_alu_y", {16'b0, alu_y}, 32'd0);
        check_eq("rst_alu_sel", {28'b0, alu_sel}, 32'd0);
        rst = 1'b0;

        // 3 x 5 with explicit busy count
        @(negedge clk);
        issue(16'd3, 16'd5, 1'b0, 1'b1);
        wait_done(0, lat, bc);
        check_eq("u3x5_latency", lat, 32'd17);
        check_eq("u3x5_busy_cycles", bc, 32'd16);
        check_eq("u3x5_prod_hi", {16'b0, prod_hi}, 32'h0000);
        check_eq("u3x5_prod_lo", {16'b0, prod_lo}, 32'h000F);
        @(negedge clk);
        check_eq("u3x5_done_one_cycle", {31'b0, done}, 32'd0);
        check_eq("u3x5_prod_held", {prod_hi, prod_lo}, 32'h0000000F);

        run_op("uffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        run_op("zero", 16'h0000, 16'h1234, 1'b0, 32'h00000000);

`ifdef CRP16_MUL_SIGNED_EN
        run_op("s_m1xm1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        run_op("s_minxmin", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
        run_op("s_maxxm1", 16'h7FFF, 16'hFFFF, 1'b1, 32'hFFFF8001);
`else
        run_op("nosgn", 16'hFFFF, 16'h0002, 1'b1, 32'h0001FFFE);
`endif

        // start pulsed again in RUN cycle 5 must be ignored
        @(negedge clk);
        issue(16'h1234, 16'h0056, 1'b0, 1'b1);
        wait_done(5, lat, bc);
        check_eq("hs_ignore_latency", lat, 32'd17);
        check_eq("hs_ignore_product", {prod_hi, prod_lo}, 32'h00061D78);

        // start during DONE launches the next op back-to-back
        @(negedge clk);
        issue(16'h00AB, 16'h0100, 1'b0, 1'b1);
        wait_done(0, lat, bc);
        issue(16'h0009, 16'h0007, 1'b0, 1'b1);
        wait_done(0, lat, bc);
        check_eq("b2b_latency", lat, 32'd17);
        check_eq("b2b_product", {prod_hi, prod_lo}, 32'h0000003F);

        // random unsigned/signed vectors through the scoreboard
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom());
            rb = 16'($urandom());
            @(negedge clk);
            issue(ra, rb, 1'(i % 2), 1'b1);
            wait_done(0, lat, bc);
            check_eq("rand_latency", lat, 32'd17);
        end

        // reset in RUN cycle 8 aborts without a done pulse
        @(negedge clk);
        issue(16'h00FF, 16'h0101, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", {31'b0, busy}, 32'd0);
        check_eq("abort_done", {31'b0, done}, 32'd0);
        check_eq("abort_prod", {prod_hi, prod_lo}, 32'd0);
        check_eq("abort_alu", {alu_x, alu_y}, 32'd0);
        check_eq("abort_alu_sel", {28'b0, alu_sel}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run_op("after_abort", 16'd2, 16'd7, 1'b0, 32'h0000000E);

        repeat (2) @(negedge clk);
        check_eq("sb_drained", exp_q.size(), 32'd0);
`ifndef CRP16_MUL_SIGNED_EN
        check_eq("alu_sel_never_nonzero", {31'b0, sel_nonzero_seen}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/crp16_mul_seq.md
# crp16_mul_seq

Iterative 16x16 multiply sequencer for the CRP16 core. It time-shares the existing 16-bit ALU: every cycle it drives the ALU operands and select, then folds the ALU result into a shift-and-add product register. A 32-bit product is ready after 16 iterations. The block sits beside the ALU in the execute stage. The execute-stage operand mux hands ALU control to this block while `busy` is high.

## Interface

Parameters:
- None. Data width is fixed at 16 to match the ALU.

Ports:
- `clk` · in · 1 · Single clock; all state updates on the rising edge.
- `reset` · in · 1 · Asynchronous, active-high reset.
- `start` · in · 1 · Request a multiply. Sampled only when `busy`=0.
- `signed_op` · in · 1 · 1 = two's-complement multiply. Honoured only when `CRP16_MUL_SIGNED_EN` is defined.
- `mcand_in` · in · 16 · Multiplicand, captured on an accepted `start`.
- `mplier_in` · in · 16 · Multiplier, captured on an accepted `start`.
- `alu_x` · out · 16 · ALU operand x.
- `alu_y` · out · 16 · ALU operand y.
- `alu_sel` · out · 4 · ALU select.
- `alu_out` · in · 16 · ALU result.
- `alu_c` · in · 1 · ALU carry flag.
- `alu_v` · in · 1 · ALU overflow flag.
- `alu_n` · in · 1 · ALU negative flag.
- `busy` · out · 1 · High during iterations.
- `done` · out · 1 · One-cycle pulse when the product becomes valid.
- `prod_hi` · out · 16 · Product bits [31:16].
- `prod_lo` · out · 16 · Product bits [15:0].

## Operation

- Internal registers:
  - `hi[15:0]`: accumulator.
  - `lo[15:0]`: multiplier, shifting out LSB-first.
  - `mcand[15:0]`.
  - `cnt[3:0]`.
  - `sgn`: latched signed mode.
  - state.
- States and transitions:
  - IDLE: `start` -> RUN. On this transition: `hi`=0, `lo`=`mplier_in`, `mcand`=`mcand_in`, `cnt`=0, `sgn`=`signed_op` (`sgn` forced to 0 without the macro).
  - RUN: one iteration per cycle. When `cnt`=15, go to DONE; otherwise increment `cnt`.
  - DONE: `done`=1 for this one cycle.
    - With `start` -> RUN (back-to-back operation, same capture as from IDLE).
    - Without `start` -> IDLE.
- ALU drive (combinational from state):
  - RUN:
    - `alu_x`=`hi`.
    - `alu_y`=`lo[0]` ? `mcand` : 0.
    - `alu_sel`: 4'b0000 (unsigned add) when `sgn`=0. When `sgn`=1: 4'b0010 (signed add), except 4'b0011 (signed sub) when `cnt`=15 and `lo[0]`=1.
  - IDLE and DONE: `alu_x`=0, `alu_y`=0, `alu_sel`=4'b0000.
- Iteration update (RUN):
  - Shift-in bit `s` = `sgn` ? (`alu_n` ^ `alu_v`) : `alu_c`.
  - `hi` <= {`s`, `alu_out[15:1]`}.
  - `lo` <= {`alu_out[0]`, `lo[15:1]`}.
- Outputs:
  - `prod_hi`=`hi`, `prod_lo`=`lo` continuously. The product is valid from the DONE cycle until the next accepted `start`.
  - `busy`=1 only in RUN.
- Boundary conditions:
  - `start` while in RUN is ignored and operands are not recaptured.
  - `start` in DONE is accepted.
  - Operands of 0 give product 0. The zero-addend path still consumes all 16 cycles (no early exit).
  - Reset asserted mid-operation aborts immediately. No `done` pulse is produced for the aborted operation.
- Reset values: state=IDLE, `hi`=`lo`=`mcand`=0, `cnt`=0, `sgn`=0. Hence `busy`=0, `done`=0, `prod_hi`=`prod_lo`=0, `alu_x`=`alu_y`=0, `alu_sel`=0.

## Timing

- `start` is sampled at edge E0. RUN occupies the 16 cycles after E0. DONE (`done`=1) is the 17th cycle after E0.
- Latency from accepted `start` to `done` is 17 cycles. Throughput with back-to-back operation is one multiply per 17 cycles.
- ALU path is combinational: register -> ALU -> register within one cycle. There is no ALU pipelining.

## Configuration

- `CRP16_MUL_SIGNED_EN` defined:
  - `signed_op` is latched into `sgn`.
  - Signed mode uses the signed ALU selects and the shift-in `alu_n`^`alu_v`.
  - The final iteration subtracts the multiplicand, giving a correct two's-complement product.
- `CRP16_MUL_SIGNED_EN` undefined:
  - `sgn` is tied to 0 and `signed_op` is ignored.
  - All multiplies are unsigned, and `alu_sel` is always 4'b0000.

## Test plan

- Unsigned: 3 x 5 -> `done` on cycle 17, `prod_hi`=0x0000, `prod_lo`=0x000F. `busy` high for exactly 16 cycles.
- Unsigned: 0xFFFF x 0xFFFF -> {`prod_hi`,`prod_lo`}=0xFFFE0001. This checks the carry shift-in.
- Signed (macro on): 0xFFFF x 0xFFFF -> 0x00000001. 0x8000 x 0x8000 -> 0x40000000. 0x7FFF x 0xFFFF -> 0xFFFF8001.
- Macro off: `signed_op`=1 with 0xFFFF x 0x0002 -> 0x0001FFFE (treated as unsigned), and `alu_sel` never nonzero.
- Handshake: `start` pulsed again in RUN cycle 5 with new operands -> ignored, original product returned. `start` held during DONE -> new operation begins, next `done` 17 cycles later.
- Reset asserted in RUN cycle 8 -> `busy`, `done`, products and ALU outputs zero immediately. A subsequent 2 x 7 gives 0x0000000E.
